// File: rtl/q_proj_pkg.sv
// Shared constants and types for the Q-projection bias datapath.
package q_proj_pkg;

  localparam int LANES      = 4;
  localparam int ACC_W      = 32;
  localparam int BIAS_DEPTH = 128;
  localparam int BIAS_AW    = 7;

  typedef logic signed [ACC_W-1:0] acc_lane_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/q_requant_lane.sv
// One requantization lane: acc + bias + half-LSB rounding, arithmetic right
// shift, then saturation to the signed output range. The sum is carried two
// bits wider than the operands so it can never wrap before saturation.
module q_requant_lane #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_bias,
  output logic [OUT_W-1:0] o_y
);

  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] RND_C   = SW'(1) << (SHIFT - 1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_shr;

  // Widened add with round-half-up, shift, and clamp to the output range.
  always_comb begin
    w_sum = $signed({{2{i_acc[ACC_W-1]}}, i_acc})
          + $signed({{2{i_bias[ACC_W-1]}}, i_bias})
          + RND_C;
    w_shr = w_sum >>> SHIFT;
    if (w_shr > SAT_MAX) begin
      o_y = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_shr < SAT_MIN) begin
      o_y = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      o_y = w_shr[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/q_bias_stream.sv
// Consumer-side sequencer for the Q-projection bias register file.
// Accepts 4-lane accumulator beats, reads the matching four bias words
// combinationally through a1..a4, requantizes each lane and presents the
// result in a single output register.
//
// Handshakes: a beat moves on either side only in a cycle where valid and
// ready are both high at the rising clock edge. Once valid is raised it stays
// high and its data stays unchanged until the beat is taken; ready may depend
// combinationally on the other side (in_ready follows out_ready).
module q_bias_stream #(
  parameter int NUM_CH = 128,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 8,
  parameter int ROW_W  = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [ROW_W-1:0]                  num_rows,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [4*ACC_W-1:0]                in_data,
  output logic [q_proj_pkg::BIAS_AW-1:0]    a1,
  output logic [q_proj_pkg::BIAS_AW-1:0]    a2,
  output logic [q_proj_pkg::BIAS_AW-1:0]    a3,
  output logic [q_proj_pkg::BIAS_AW-1:0]    a4,
  input  logic [4*ACC_W-1:0]                bias,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [4*OUT_W-1:0]                out_data,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output q_proj_pkg::state_e                dbg_state
);

  import q_proj_pkg::*;

  localparam logic [BIAS_AW-1:0] LAST_CH = BIAS_AW'(NUM_CH - LANES);
  localparam logic [BIAS_AW-1:0] CH_STEP = BIAS_AW'(LANES);

  state_e              r_state;
  logic [BIAS_AW-1:0]  r_ch_base;
  logic [ROW_W-1:0]    r_row_cnt;
  logic [ROW_W-1:0]    r_num_rows;
  logic                r_out_valid;
  logic                r_out_last;
  logic [4*OUT_W-1:0]  r_out_data;
  logic                r_busy;
  logic                r_done;

  logic                w_accept;
  logic                w_out_fire;
  logic                w_wrap;
  logic                w_last_beat;
  logic [4*OUT_W-1:0]  w_req;

  // Upstream may only push while running and the output slot is free or
  // being emptied this cycle.
  assign in_ready    = (r_state == RUN) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_wrap      = (r_ch_base == LAST_CH);
  assign w_last_beat = w_wrap && (r_row_cnt == (r_num_rows - ROW_W'(1)));

  // Bias addresses follow the registered channel base; parked at 0 when idle.
  assign a1 = r_busy ? r_ch_base                  : '0;
  assign a2 = r_busy ? r_ch_base + BIAS_AW'(1)    : '0;
  assign a3 = r_busy ? r_ch_base + BIAS_AW'(2)    : '0;
  assign a4 = r_busy ? r_ch_base + BIAS_AW'(3)    : '0;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    q_requant_lane #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .i_acc  (in_data[k*ACC_W +: ACC_W]),
      .i_bias (bias[k*ACC_W +: ACC_W]),
      .o_y    (w_req[k*OUT_W +: OUT_W])
    );
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

  // Job sequencer: row/channel counters, output register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ch_base   <= '0;
      r_row_cnt   <= '0;
      r_num_rows  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (num_rows != '0) begin
              r_state    <= RUN;
              r_num_rows <= num_rows;
              r_ch_base  <= '0;
              r_row_cnt  <= '0;
              r_busy     <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_out_data  <= w_req;
            r_out_valid <= 1'b1;
            if (w_wrap) begin
              r_ch_base <= '0;
              r_row_cnt <= r_row_cnt + ROW_W'(1);
            end else begin
              r_ch_base <= r_ch_base + CH_STEP;
            end
            if (w_last_beat) begin
              r_out_last <= 1'b1;
              r_state    <= DRAIN;
            end
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            r_done      <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_bias_stream.sv
// Directed bench for q_bias_stream: table of hand-computed requantization
// vectors, plus hand-written multi-cycle sequences for wrap, backpressure,
// zero-row jobs, restart while busy and reset mid-job.
module tb_q_bias_stream;

  localparam int NUM_CH = 128;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 16;
  localparam int ROW_W  = 10;
  localparam int BPR    = NUM_CH / 4;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [ROW_W-1:0]     num_rows;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*ACC_W-1:0]   in_data;
  logic [6:0]           a1, a2, a3, a4;
  logic [4*ACC_W-1:0]   bias;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*OUT_W-1:0]   out_data;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  q_proj_pkg::state_e   dbg_state;

  q_bias_stream #(
    .NUM_CH (NUM_CH), .ACC_W (ACC_W), .OUT_W (OUT_W), .SHIFT (8), .ROW_W (ROW_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .a4        (a4),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bias register file model ----------------
  logic [31:0] bias_mem [NUM_CH];
  assign bias = {bias_mem[a4], bias_mem[a3], bias_mem[a2], bias_mem[a1]};

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [64:0]  exp_q[$];
  logic [127:0] src_q[$];
  logic [63:0]  exp_data[$];

  typedef struct {
    logic [127:0] acc;
    logic [63:0]  exp;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_lane(input logic [31:0] acc, input logic [31:0] b);
    longint s;
    s = longint'($signed(acc)) + longint'($signed(b)) + 128;
    s = s >>> 8;
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic [63:0] ref_beat(input logic [127:0] d, input int ch);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = ref_lane(d[k*32 +: 32], bias_mem[ch+k]);
    return r;
  endfunction

  // Build the source beats and their expected outputs for a job.
  task automatic prepare_job(input int total, input bit use_table);
    logic [31:0]  v;
    logic [127:0] d;
    src_q.delete();
    exp_data.delete();
    for (int i = 0; i < total; i++) begin
      if (use_table && i < 6) begin
        src_q.push_back(vt[i].acc);
        exp_data.push_back(vt[i].exp);
      end else begin
        for (int k = 0; k < 4; k++) begin
          v = $urandom;
          if ($urandom_range(0, 3) != 0) v = {{12{v[31]}}, v[31:12]};
          d[k*32 +: 32] = v;
        end
        src_q.push_back(d);
        exp_data.push_back(ref_beat(d, (i % BPR) * 4));
      end
    end
  endtask

  // Drive one job and score every cycle until done (or until reset_at).
  task automatic stream_job(input int nrows, input bit rand_ready, input bit rand_valid,
                            input int restart_at, input int reset_at);
    int total, sent, got, cyc, fin_cyc;
    bit restarted, last_fire, prev_stall, finished;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [64:0] e;
    logic [6:0]  m_ch;
    total = nrows * BPR;
    sent = 0; got = 0; fin_cyc = 0; m_ch = '0;
    restarted = 0; last_fire = 0; prev_stall = 0; finished = 0;
    prev_data = '0; prev_last = 0;
    exp_q.delete();
    start = 1'b1; num_rows = ROW_W'(nrows);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    for (cyc = 0; cyc < 4000 && !finished; cyc++) begin
      in_valid  = (sent < total) && (!rand_valid || $urandom_range(0, 3) != 0);
      in_data   = (sent < total) ? src_q[sent] : {$urandom, $urandom, $urandom, $urandom};
      out_ready = !rand_ready || ($urandom_range(0, 1) == 1);
      start     = 1'b0;
      if (restart_at >= 0 && !restarted && sent >= restart_at) begin
        start = 1'b1; num_rows = ROW_W'(7); restarted = 1;
      end
      if (reset_at >= 0 && sent == reset_at) begin
        rst_n = 1'b0; in_valid = 1'b0; #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_done",      64'(done),      64'd0);
        check("rst_addr",      64'({a1, a2, a3, a4}), 64'd0);
        check("rst_state",     64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      @(negedge clk);
      if (last_fire) begin
        check("done_pulse",         64'(done),      64'd1);
        check("busy_fall",          64'(busy),      64'd0);
        check("out_valid_after_done", 64'(out_valid), 64'd0);
        finished = 1;
        fin_cyc  = cyc;
      end else begin
        check("done_quiet", 64'(done), 64'd0);
        check("busy_high",  64'(busy), 64'd1);
        check("in_ready_rule", 64'(in_ready),
              64'((sent < total) ? (!out_valid || out_ready) : 1'b0));
        if (prev_stall) begin
          check("hold_data", out_data, prev_data);
          check("hold_last", 64'(out_last), 64'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL extra_beat: got data 0x%0h expected no beat", out_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e[63:0]);
            check("beat_last", 64'(out_last), 64'(e[64]));
            got++;
            if (e[64]) last_fire = 1;
          end
        end
        if (in_valid && in_ready) begin
          check("addr", 64'({a1, a2, a3, a4}),
                64'({m_ch, m_ch + 7'd1, m_ch + 7'd2, m_ch + 7'd3}));
          exp_q.push_back({(sent == total - 1), exp_data[sent]});
          sent++;
          m_ch = m_ch + 7'd4;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: job of %0d rows got %0d beats, required %0d", nrows, got, total);
    end
    check("beat_count",  64'(got),          64'(total));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    if (!rand_ready && !rand_valid) check("throughput_cycles", 64'(fin_cyc), 64'(total + 1));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Repeating 4-channel bias pattern; ch0 and ch1 as the plan fixes them.
    for (int c = 0; c < NUM_CH; c++) begin
      case (c % 4)
        0:       bias_mem[c] = 32'h00000082;
        1:       bias_mem[c] = 32'hFFFFFA8C;
        2:       bias_mem[c] = 32'h00000000;
        default: bias_mem[c] = 32'hFFFFFF80;
      endcase
    end
    // Hand-computed vectors for bias lanes {130, -1396, 0, -128}.
    vt[0] = '{acc: {32'h00000000, 32'h00000000, 32'h00000000, 32'h00001000},
              exp: {16'h0000, 16'h0000, 16'hFFFB, 16'h0011}};
    vt[1] = '{acc: {32'hFFFFFF7F, 32'h00000080, 32'h80000000, 32'h7FFFFFFF},
              exp: {16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF}};
    vt[2] = '{acc: {32'h00000000, 32'h0000007F, 32'h00000574, 32'hFFFFFF00},
              exp: {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vt[3] = '{acc: {32'h00010000, 32'hFFFFFF00, 32'hFF800000, 32'h007FFF00},
              exp: {16'h0100, 16'hFFFF, 16'h8000, 16'h7FFF}};
    vt[4] = '{acc: {32'hFFFF8000, 32'hFFFFFF7F, 32'h00000000, 32'h00007E7E},
              exp: {16'hFF80, 16'hFFFF, 16'hFFFB, 16'h007F}};
    vt[5] = '{acc: {32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000},
              exp: {16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000}};

    start = 1'b0; num_rows = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd0);
    check("reset_out_data",  out_data,       64'd0);
    check("reset_out_last",  64'(out_last),  64'd0);
    check("reset_busy",      64'(busy),      64'd0);
    check("reset_done",      64'(done),      64'd0);
    check("reset_addr",      64'({a1, a2, a3, a4}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors as the first beats of a one-row job, full throughput.
    prepare_job(BPR, 1'b1);
    stream_job(1, 1'b0, 1'b0, -1, -1);

    // Two rows: channel wrap, out_last on beat 63, done timing.
    prepare_job(2 * BPR, 1'b0);
    stream_job(2, 1'b0, 1'b0, -1, -1);

    // Random backpressure and bubbles, with a start pulse mid-job.
    prepare_job(3 * BPR, 1'b1);
    stream_job(3, 1'b1, 1'b1, 20, -1);

    // Zero-row job, and in_valid while idle.
    in_valid = 1'b1; in_data = src_q[0];
    start = 1'b1; num_rows = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done",      64'(done),      64'd1);
    check("zero_busy",      64'(busy),      64'd0);
    check("zero_in_ready",  64'(in_ready),  64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_done_clear", 64'(done),      64'd0);
      check("zero_no_beat",    64'(out_valid), 64'd0);
      check("idle_in_ready",   64'(in_ready),  64'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset at beat 10, then a clean job from channel 0.
    prepare_job(2 * BPR, 1'b0);
    stream_job(2, 1'b0, 1'b0, -1, 10);
    @(posedge clk); #1;
    prepare_job(BPR, 1'b1);
    stream_job(1, 1'b1, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
